// File: rtl/truth_sweep_ctrl.sv
// truth_sweep_ctrl
//   Sequencer/checker for the 4-input composite logic stage. On start it
//   walks {a,b,c,d} through 0..15, holding each vector SETTLE cycles, samples
//   the composite output e on the last hold cycle, assembles a 16-bit
//   signature and compares it against the golden truth table EXPECTED.
//
//   Build option: define SWEEP_EARLY_ABORT_EN to stop the sweep at the first
//   mismatching vector (vec_out then holds the failing index). Undefined
//   (default): all 16 vectors are swept and every mismatch is counted.
//
// Parameters
//   SETTLE    cycles each vector is held before sampling (1..15)
//   EXPECTED  golden truth table, bit i = expected e for {a,b,c,d} = i
// Ports
//   clk            rising-edge clock
//   rst_n          async active-low reset
//   start          sweep request (ignored while busy)
//   resp_in        composite output e
//   vec_out        {a,b,c,d} to composite, bit 3 = a
//   busy           sweep in progress
//   done           sweep complete (level, held until next start/reset)
//   pass           signature matched EXPECTED (valid while done)
//   signature      captured responses, bit i = e sampled for vector i
//   mismatch_cnt   number of mismatching vectors, 0..16
//   first_fail_idx lowest mismatching vector, 0 if none
module truth_sweep_ctrl #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'hF410
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        resp_in,
  output logic [3:0]  vec_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail_idx
);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] CNT_LD = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       launch;   // start accepted this edge (IDLE or DONE)
  logic       sample;   // last hold cycle of the current vector
  logic       miss;     // sampled response disagrees with golden
  logic       last;     // sampling the final vector of the sweep
  logic       stop;     // sweep ends at this sample

  assign launch = start && (state_q != HOLD);
  assign sample = (state_q == HOLD) && (cnt_q == 4'd0);
  assign miss   = sample && (resp_in != EXPECTED[vec_out]);
  assign last   = (vec_out == 4'd15);

`ifdef SWEEP_EARLY_ABORT_EN
  assign stop = sample && (last || miss);
`else
  assign stop = sample && last;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = HOLD;
      HOLD:    if (stop)  state_d = DONE;
      DONE:    if (start) state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state_q)
      HOLD: busy = 1'b1;
      DONE: begin
        done = 1'b1;
        pass = (mismatch_cnt == 5'd0);
      end
      default: ;
    endcase
  end

  // Sweep datapath: vector index, settle counter, result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out        <= '0;
      cnt_q          <= '0;
      signature      <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
    end else if (launch || state_q == IDLE) begin
      // IDLE keeps everything cleared; a launch from DONE clears identically
      vec_out        <= '0;
      cnt_q          <= CNT_LD;
      signature      <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
    end else if (state_q == HOLD) begin
      if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end else begin
        signature[vec_out] <= resp_in;
        if (miss) begin
          mismatch_cnt <= mismatch_cnt + 5'd1;
          if (mismatch_cnt == 5'd0) first_fail_idx <= vec_out;
        end
        // On stop vec_out is left on the last/failing vector
        if (!stop) begin
          vec_out <= vec_out + 4'd1;
          cnt_q   <= CNT_LD;
        end
      end
    end
  end

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
module tb_truth_sweep_ctrl;

  localparam int          SETTLE = 2;
  localparam logic [15:0] EXP    = 16'hF410;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        resp_in;
  logic [3:0]  vec_out;
  logic        busy, done, pass;
  logic [15:0] signature;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail_idx;

  // Behavioural composite: truth table the bench can corrupt per test
  logic [15:0] resp_tab = EXP;
  assign resp_in = resp_tab[vec_out];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  truth_sweep_ctrl #(.SETTLE(SETTLE), .EXPECTED(EXP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_in(resp_in),
    .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .mismatch_cnt(mismatch_cnt),
    .first_fail_idx(first_fail_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_vec"},  32'(vec_out), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done"}, 32'(done), 0);
    chk({pfx, "_pass"}, 32'(pass), 0);
    chk({pfx, "_sig"},  32'(signature), 0);
    chk({pfx, "_mm"},   32'(mismatch_cnt), 0);
    chk({pfx, "_ff"},   32'(first_fail_idx), 0);
  endtask

  // One sweep with the composite returning EXP ^ mask. Reference results are
  // derived from the truth table directly; timing from the k + n*SETTLE rules.
  task automatic run_sweep(input logic [15:0] mask, input bit repulse);
    logic [15:0] e_sig = '0;
    int e_mm = 0, e_ff = 0, e_stop = 15, t = 0, len;
    bit fired = 0;
    for (int i = 0; i < 16; i++) begin
      logic r = EXP[i] ^ mask[i];
      e_sig[i] = r;
      if (mask[i]) begin
        if (e_mm == 0) e_ff = i;
        e_mm++;
`ifdef SWEEP_EARLY_ABORT_EN
        e_stop = i;
        break;
`endif
      end
    end
    len = (e_stop + 1) * SETTLE;
    resp_tab = EXP ^ mask;

    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;           // edge k
    chk("k_busy", 32'(busy), 1);
    chk("k_done", 32'(done), 0);
    chk("k_vec",  32'(vec_out), 0);
    chk("k_sig",  32'(signature), 0);
    chk("k_mm",   32'(mismatch_cnt), 0);
    chk("k_pass", 32'(pass), 0);

    while (t < len) begin
      if (repulse && !fired && vec_out == 4'd5) begin
        start = 1'b1;
        fired = 1;
      end
      @(posedge clk); #1; start = 1'b0;
      t++;
      if (t < len) begin
        chk("run_busy", 32'(busy), 1);
        chk("run_vec",  32'(vec_out), 32'(t / SETTLE));
      end
    end
    // edge k + len
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_sig",  32'(signature), 32'(e_sig));
    chk("end_mm",   32'(mismatch_cnt), 32'(e_mm));
    chk("end_ff",   32'(first_fail_idx), 32'(e_ff));
    chk("end_pass", 32'(pass), 32'(e_mm == 0));
    chk("end_vec",  32'(vec_out), 32'(e_stop));
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", 32'(done), 1);
    chk("hold_sig",  32'(signature), 32'(e_sig));
    chk("hold_vec",  32'(vec_out), 32'(e_stop));
  endtask

  initial begin
    #2 chk_zero("rst");
    #20 @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero("idle");

    run_sweep(16'h0000, 0);        // golden composite
    run_sweep(EXP, 0);             // resp tied 0
    run_sweep(~EXP, 0);            // resp tied 1
    run_sweep(16'h0000, 1);        // start re-pulsed mid-sweep
    run_sweep(16'h8000, 0);        // only the final vector fails

    // Async reset mid-sweep at vector 7
    resp_tab = EXP;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 40 && vec_out != 4'd7; c++) begin
      @(posedge clk); #1;
    end
    chk("reach7", 32'(vec_out), 7);
    #2 rst_n = 1'b0;
    #1 chk_zero("arst");
    @(negedge clk); rst_n = 1'b1;
    run_sweep(16'h0000, 0);

    for (int n = 0; n < 8; n++) begin
      logic [15:0] m = 16'($urandom);
      if (n == 3) m = '0;
      run_sweep(m, n[0]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
